// File: rtl/game_sequencer.sv
// Frogger-style game flow sequencer: spawn, play, death/win freeze holds,
// level and lives bookkeeping. All outputs are registered.
module game_sequencer #(
   parameter int LIVES      = 3,
   parameter int MAX_LEVEL  = 9,
   parameter int DEATH_HOLD = 60,
   parameter int WIN_HOLD   = 30
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       death_collision,
   input  logic       win_collision,
   output logic       play_reset,
   output logic [3:0] current_level,
   output logic [1:0] lives,
   output logic [2:0] game_state,
   output logic       game_over
);

   localparam int HOLD_MAX = (DEATH_HOLD > WIN_HOLD) ? DEATH_HOLD : WIN_HOLD;
   localparam int HW       = $clog2(HOLD_MAX + 1);

   localparam logic [3:0]    MAX_LVL    = 4'(MAX_LEVEL);
   localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
   localparam logic [HW-1:0] DH         = HW'(DEATH_HOLD);
   localparam logic [HW-1:0] WH         = HW'(WIN_HOLD);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SPAWN     = 3'd1,
      PLAY      = 3'd2,
      DYING     = 3'd3,
      WINNING   = 3'd4,
      GAME_OVER = 3'd5
   } state_e;

   state_e        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d, hold_inc;
   logic [3:0]    level_q, level_d;
   logic [1:0]    lives_q, lives_d;
   logic          play_reset_q, play_reset_d;
   logic          game_over_q, game_over_d;

   assign hold_inc = hold_q + 1'b1;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      level_d = level_q;
      lives_d = lives_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SPAWN;
               level_d = '0;
               lives_d = LIVES_INIT;
            end
         end
         SPAWN: state_d = PLAY;
         PLAY: begin
            // restart beats collisions; a simultaneous win/death counts as a win
            if (start) begin
               state_d = SPAWN;
               level_d = '0;
               lives_d = LIVES_INIT;
            end else if (win_collision) begin
               state_d = WINNING;
               hold_d  = '0;
               level_d = (level_q == MAX_LVL) ? 4'd0 : level_q + 4'd1;
            end else if (death_collision) begin
               state_d = DYING;
               hold_d  = '0;
               lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            end
         end
         DYING: begin
            if (frame_tick) begin
               if (hold_inc >= DH) begin
                  state_d = (lives_q == 2'd0) ? GAME_OVER : SPAWN;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_inc;
               end
            end
         end
         WINNING: begin
            if (frame_tick) begin
               if (hold_inc >= WH) begin
                  state_d = SPAWN;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_inc;
               end
            end
         end
         GAME_OVER: begin
            if (start) begin
               state_d = SPAWN;
               level_d = '0;
               lives_d = LIVES_INIT;
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = '0;
         end
      endcase
      play_reset_d = (state_d != PLAY);
      game_over_d  = (state_d == GAME_OVER);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         level_q      <= '0;
         lives_q      <= LIVES_INIT;
         play_reset_q <= 1'b1;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         level_q      <= level_d;
         lives_q      <= lives_d;
         play_reset_q <= play_reset_d;
         game_over_q  <= game_over_d;
      end
   end

   assign play_reset    = play_reset_q;
   assign current_level = level_q;
   assign lives         = lives_q;
   assign game_state    = state_q;
   assign game_over     = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios with literal expectations,
// then randomized traffic against a behavioural game model.
module tb_game_sequencer;

   localparam int LIVES      = 3;
   localparam int MAX_LEVEL  = 9;
   localparam int DEATH_HOLD = 2;
   localparam int WIN_HOLD   = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic       death_collision = 1'b0;
   logic       win_collision = 1'b0;
   logic       play_reset;
   logic [3:0] current_level;
   logic [1:0] lives;
   logic [2:0] game_state;
   logic       game_over;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   game_sequencer #(
      .LIVES(LIVES), .MAX_LEVEL(MAX_LEVEL),
      .DEATH_HOLD(DEATH_HOLD), .WIN_HOLD(WIN_HOLD)
   ) dut (
      .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .start(start),
      .death_collision(death_collision), .win_collision(win_collision),
      .play_reset(play_reset), .current_level(current_level), .lives(lives),
      .game_state(game_state), .game_over(game_over)
   );

   always #5 clk = ~clk;

   // Behavioural game model: phase number, level, lives, frozen ticks left.
   int m_st = 0, m_lvl = 0, m_liv = LIVES, m_left = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_st <= 0; m_lvl <= 0; m_liv <= LIVES; m_left <= 0;
      end else begin
         case (m_st)
            0, 5: if (start) begin m_st <= 1; m_lvl <= 0; m_liv <= LIVES; end
            1: m_st <= 2;
            2: begin
               if (start) begin
                  m_st <= 1; m_lvl <= 0; m_liv <= LIVES;
               end else if (win_collision) begin
                  m_st <= 4; m_lvl <= (m_lvl + 1) % (MAX_LEVEL + 1); m_left <= WIN_HOLD;
               end else if (death_collision) begin
                  m_st <= 3; m_liv <= (m_liv > 0) ? m_liv - 1 : 0; m_left <= DEATH_HOLD;
               end
            end
            3, 4: if (frame_tick) begin
               m_left <= m_left - 1;
               if (m_left == 1) m_st <= (m_st == 3 && m_liv == 0) ? 5 : 1;
            end
            default: m_st <= 0;
         endcase
      end
   end

   // Per-cycle compare of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         logic [10:0] act, exp;
         act = {game_state, play_reset, current_level, lives, game_over};
         exp = {3'(m_st), (m_st != 2), 4'(m_lvl), 2'(m_liv), (m_st == 5)};
         n_cmp++;
         if (act !== exp) begin
            n_err++;
            $display("FAIL model t=%0t got st=%0d pr=%0b lvl=%0d liv=%0d go=%0b want st=%0d pr=%0b lvl=%0d liv=%0d go=%0b",
                     $time, act[10:8], act[7], act[6:3], act[2:1], act[0],
                     exp[10:8], exp[7], exp[6:3], exp[2:1], exp[0]);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s got %0d want %0d", nm, act, exp);
      end
   endtask

   // Apply inputs for one clock edge, return 2 time units after it
   task automatic cyc(input bit s, input bit d, input bit w, input bit t);
      start = s; death_collision = d; win_collision = w; frame_tick = t;
      @(posedge clk); #2;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      chk_en = 1'b1;
      chk("rst_state", int'(game_state), 0);
      chk("rst_play_reset", int'(play_reset), 1);
      chk("rst_lives", int'(lives), 3);
      chk("rst_level", int'(current_level), 0);
      chk("rst_game_over", int'(game_over), 0);
      reset_n = 1'b1;

      cyc(0, 0, 0, 0);
      chk("idle_hold", int'(game_state), 0);
      cyc(1, 0, 0, 0);
      chk("spawn_state", int'(game_state), 1);
      chk("spawn_play_reset", int'(play_reset), 1);
      cyc(0, 0, 0, 0);
      chk("play_state", int'(game_state), 2);
      chk("play_play_reset", int'(play_reset), 0);
      chk("play_level", int'(current_level), 0);
      chk("play_lives", int'(lives), 3);

      // win held across the whole hold and spawn
      cyc(0, 0, 1, 0);
      chk("win_state", int'(game_state), 4);
      chk("win_level", int'(current_level), 1);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 1);
      chk("win_hold_1tick", int'(game_state), 4);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 1);
      chk("win_exit_spawn", int'(game_state), 1);
      chk("win_level_once", int'(current_level), 1);
      cyc(0, 0, 1, 0);
      chk("win_back_play", int'(game_state), 2);
      cyc(0, 0, 0, 0);
      chk("win_level_final", int'(current_level), 1);

      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 0, 0);
         chk("die_state", int'(game_state), 3);
         chk("die_lives", int'(lives), 2 - i);
         if (i == 1) begin
            cyc(1, 0, 0, 0);
            chk("die_start_ignored", int'(game_state), 3);
         end
         cyc(0, 0, 0, 1);
         cyc(0, 0, 0, 1);
         if (i < 2) begin
            chk("die_exit_spawn", int'(game_state), 1);
            cyc(0, 0, 0, 0);
         end else begin
            chk("gameover_state", int'(game_state), 5);
            chk("gameover_flag", int'(game_over), 1);
            chk("gameover_level_frozen", int'(current_level), 1);
         end
      end
      cyc(0, 0, 0, 0);
      chk("gameover_stays", int'(game_state), 5);
      cyc(1, 0, 0, 0);
      chk("restart_spawn", int'(game_state), 1);
      cyc(0, 0, 0, 0);
      chk("restart_play", int'(game_state), 2);
      chk("restart_level", int'(current_level), 0);
      chk("restart_lives", int'(lives), 3);

      for (int i = 1; i <= 10; i++) begin
         cyc(0, 0, 1, 0);
         chk("wins_level", int'(current_level), i % 10);
         cyc(0, 0, 0, 1);
         cyc(0, 0, 0, 1);
         cyc(0, 0, 0, 0);
      end

      cyc(0, 1, 1, 0);
      chk("both_state", int'(game_state), 4);
      chk("both_level", int'(current_level), 1);
      chk("both_lives", int'(lives), 3);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);

      // reset in the middle of a death hold
      cyc(0, 1, 0, 0);
      chk("mid_die_lives", int'(lives), 2);
      cyc(0, 0, 0, 1);
      reset_n = 1'b0;
      #1;
      chk("async_rst_state", int'(game_state), 0);
      chk("async_rst_lives", int'(lives), 3);
      chk("async_rst_level", int'(current_level), 0);
      chk("async_rst_play_reset", int'(play_reset), 1);
      @(posedge clk); #2;
      reset_n = 1'b1;

      for (int i = 0; i < 5000; i++) begin
         start = ($urandom_range(0, 15) == 0);
         death_collision = ($urandom_range(0, 5) == 0);
         win_collision = ($urandom_range(0, 7) == 0);
         frame_tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 399) == 0) reset_n = 1'b0;
         @(posedge clk); #2;
         reset_n = 1'b1;
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
